rhd_sample_packetizer: RTL and testbench
========================================

# rhd_sample_packetizer

Frames RHD channel samples into DMA-ready AXI-Stream packets. Sits directly downstream of the RHD MISO capture/deskew stage (the stage programmed through the per-line delay register) and directly upstream of the DMA S2MM stream port. Each frame gets a 64-bit magic header and an optional frame counter. The block groups `batch_size` frames into one packet terminated by `tlast`.

## Interface
- `NUM_CH`, 32: channel words per frame (2..64).
- `MAGIC`, 64'hC691_1999_2813_49AB: header constant, sent low word first.
- `rhd_aclk` in 1: sole clock.
- `rhd_aresetn` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: packetizing enable, level.
- `batch_size` in 8: frames per packet; sampled at packet start; 0 is treated as 1.
- `s_tdata` in 32: channel sample word from capture stage.
- `s_tvalid` in 1: sample valid.
- `s_tready` out 1: sample accept.
- `s_tlast` in 1: capture stage's end-of-frame marker; checked only, never used for length.
- `m_axis_tdata` out 32: packet word to DMA.
- `m_axis_tvalid` out 1: packet word valid.
- `m_axis_tready` in 1: DMA accept.
- `m_axis_tlast` out 1: last word of packet.
- `err_clr` in 1: one-cycle pulse clearing `err_len`.
- `err_len` out 1: sticky frame-length error.
- `frame_cnt` out 32: frames emitted since reset.

## Operation
- The FSM has five states: IDLE, HDR_LO, HDR_HI, TS, DATA.
- **IDLE**
  - Exit when `enable`=1 and `s_tvalid`=1.
  - On exit, latch `batch_size` into `bs_q` (0→1) and clear the frame-in-batch counter `fib`.
  - Go to HDR_LO.
- **HDR_LO / HDR_HI:** emit `MAGIC[31:0]`, then `MAGIC[63:32]`.
- **TS:** emit `frame_cnt` (value before increment). Present only with the configuration macro; otherwise HDR_HI goes directly to DATA.
- **DATA:** pass `NUM_CH` input words through. The channel counter `ch` runs 0..NUM_CH-1.
- **Frame end:** on acceptance of the word with `ch`=NUM_CH-1:
  - `frame_cnt` += 1, wrapping 2^32−1→0.
  - `fib` += 1.
  - If `fib`+1 = `bs_q`: assert `m_axis_tlast` on that word. Then go to IDLE if `enable`=0, else HDR_LO with a fresh `bs_q`.
  - Otherwise go to HDR_LO with no `tlast`.
- **`enable` deassert:** mid-packet deassertion has no effect until the packet completes. A packet is never truncated.
- **Length check:** on each accepted input word, `s_tlast` must equal (`ch`=NUM_CH-1). Any mismatch sets `err_len`.
  - The block keeps framing by count and does not resynchronise.
  - `err_clr` clears `err_len`. If `err_clr` and a new mismatch occur in the same cycle, set wins.
- **Input stall:** `s_tready`=0 in every state except DATA. Header words never consume input.

## Timing
- **Output register:** a single output register stage, AXI-Stream compliant. `m_axis_tdata` and `m_axis_tlast` are held stable while `tvalid`=1 and `tready`=0.
- **DATA state:** `s_tready` = `!m_axis_tvalid || m_axis_tready`. An input accepted in cycle N appears on `m_axis_tdata` in cycle N+1.
- **Header states:** the next header word loads when the output register is empty or being accepted. Full throughput is one word per cycle with `m_axis_tready` held high.
- **IDLE→HDR_LO:** `m_axis_tvalid` rises on the cycle after the IDLE exit condition.
- **Packet length:** `bs_q`×(NUM_CH+2) words, or `bs_q`×(NUM_CH+3) with TS.
- **Reset values:**
  - State = IDLE.
  - All counters = 0, `bs_q` = 1.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `s_tready`=0, `err_len`=0, `frame_cnt`=0.
- **Reset mid-packet:** the partial packet is abandoned with no `tlast`. The DMA side is reset by the same `rhd_aresetn` domain release.

## Configuration
- `RHD_PKT_TIMESTAMP_EN` defined: the TS state is compiled in, and each frame is NUM_CH+3 words (magic lo, magic hi, counter, data).
- `RHD_PKT_TIMESTAMP_EN` undefined: the TS state is removed and each frame is NUM_CH+2 words. `frame_cnt` still counts and is visible on its port.

## Test plan
- **Basic packet:** NUM_CH=32, `batch_size`=8, macro off, `tready`=1, continuous valid input with correct `s_tlast`.
  - 272 words out; words 0/1 = 0x281349AB/0xC6911999.
  - `tlast` only on word 271; `frame_cnt`=8; `err_len`=0.
- **Timestamp mode:** macro on, `batch_size`=0.
  - One frame per packet of 35 words; word 2 = 0,1,2… across successive packets; `tlast` on every word 34.
- **Backpressure:** `tready` toggled by a random 50% pattern.
  - Output sequence is identical to the `tready`=1 run; `tdata`/`tlast` stable while stalled.
  - `s_tready`=0 during stalls with a full register.
- **Length error:** `s_tlast` asserted on channel 30 of frame 2.
  - `err_len`=1 from the next cycle and framing is unchanged.
  - `err_clr` pulse → 0; simultaneous `err_clr` + mismatch → 1.
- **Graceful disable:** `enable` dropped at word 100 of a 4-frame packet.
  - Packet completes with `tlast` at word 135; returns to IDLE; no further output.
- **Reset mid-packet:** `rhd_aresetn` low during DATA.
  - All outputs go to reset values immediately; after release with `enable`=1, the next packet starts with magic lo and `frame_cnt` restarts from 0.

Source files
------------

// File: rtl/rhd_sample_packetizer.sv
// rhd_sample_packetizer
//   Frames RHD channel samples into DMA-ready AXI-Stream packets. Every frame
//   is a 64-bit magic header (low word first), an optional frame counter word,
//   then NUM_CH channel words. batch_size frames form one packet ended by tlast.
//
//   Optional feature macro: RHD_PKT_TIMESTAMP_EN
//     defined   -> a frame-counter word follows the header (NUM_CH+3 words/frame)
//     undefined -> no counter word (NUM_CH+2 words/frame); frame_cnt still counts
//
// Ports
//   rhd_aclk, rhd_aresetn        clock, async-assert active-low reset
//   enable                       packetizing enable (level, honoured between packets)
//   batch_size[7:0]              frames per packet, sampled at packet start, 0 -> 1
//   s_tdata/s_tvalid/s_tready    sample stream from the capture stage
//   s_tlast                      capture-side end-of-frame, compared only
//   m_axis_tdata/tvalid/tready/tlast  packet stream to the DMA
//   err_clr                      clears err_len (a coincident new error wins)
//   err_len                      sticky frame-length error
//   frame_cnt[31:0]              frames emitted since reset
module rhd_sample_packetizer #(
  parameter int          NUM_CH = 32,
  parameter logic [63:0] MAGIC  = 64'hC691_1999_2813_49AB
) (
  input  logic        rhd_aclk,
  input  logic        rhd_aresetn,
  input  logic        enable,
  input  logic [7:0]  batch_size,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        err_clr,
  output logic        err_len,
  output logic [31:0] frame_cnt
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
`ifdef RHD_PKT_TIMESTAMP_EN
    TS     = 3'd3,
`endif
    DATA   = 3'd4
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   ch_reg;
  logic [7:0]      fib_reg;
  logic [7:0]      bs_q_reg;
  logic [31:0]     tdata_reg;
  logic            tvalid_reg;
  logic            tlast_reg;
  logic            err_reg;
  logic [31:0]     fcnt_reg;

  // Output register can take a new word this cycle.
  logic       out_ok;
  logic       in_fire;
  logic       last_ch;
  logic       last_frame;
  logic [7:0] bs_eff;

  assign out_ok     = !tvalid_reg || m_axis_tready;
  assign in_fire    = (state_reg == DATA) && s_tvalid && out_ok;
  assign last_ch    = (ch_reg == CW'(NUM_CH - 1));
  // 9-bit compare so fib+1 cannot wrap when bs_q is 255.
  assign last_frame = (({1'b0, fib_reg} + 9'd1) == {1'b0, bs_q_reg});
  assign bs_eff     = (batch_size == 8'd0) ? 8'd1 : batch_size;

  assign s_tready      = (state_reg == DATA) && out_ok;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign err_len       = err_reg;
  assign frame_cnt     = fcnt_reg;

  always_ff @(posedge rhd_aclk or negedge rhd_aresetn) begin
    if (!rhd_aresetn) begin
      state_reg  <= IDLE;
      ch_reg     <= '0;
      fib_reg    <= 8'd0;
      bs_q_reg   <= 8'd1;
      tdata_reg  <= 32'd0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      err_reg    <= 1'b0;
      fcnt_reg   <= 32'd0;
    end else begin
      // Word taken by the DMA; any load below overrides this.
      if (m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end

      // Length check: set has priority over clear.
      if (in_fire && (s_tlast != last_ch)) begin
        err_reg <= 1'b1;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // The low magic word is loaded on the exit edge itself so tvalid
          // rises one cycle after the start condition; the FSM then continues
          // with the high word.
          if (enable && s_tvalid && out_ok) begin
            bs_q_reg   <= bs_eff;
            fib_reg    <= 8'd0;
            tdata_reg  <= MAGIC[31:0];
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            state_reg  <= HDR_HI;
          end
        end
        HDR_LO: begin
          if (out_ok) begin
            tdata_reg  <= MAGIC[31:0];
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            state_reg  <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (out_ok) begin
            tdata_reg  <= MAGIC[63:32];
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
`ifdef RHD_PKT_TIMESTAMP_EN
            state_reg  <= TS;
`else
            state_reg  <= DATA;
`endif
          end
        end
`ifdef RHD_PKT_TIMESTAMP_EN
        TS: begin
          if (out_ok) begin
            tdata_reg  <= fcnt_reg;
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            state_reg  <= DATA;
          end
        end
`endif
        DATA: begin
          if (in_fire) begin
            tdata_reg  <= s_tdata;
            tvalid_reg <= 1'b1;
            tlast_reg  <= last_ch && last_frame;
            if (last_ch) begin
              ch_reg   <= '0;
              fcnt_reg <= fcnt_reg + 32'd1;
              if (last_frame) begin
                // Packet complete: enable is only honoured here.
                if (enable) begin
                  bs_q_reg  <= bs_eff;
                  fib_reg   <= 8'd0;
                  state_reg <= HDR_LO;
                end else begin
                  state_reg <= IDLE;
                end
              end else begin
                fib_reg   <= fib_reg + 8'd1;
                state_reg <= HDR_LO;
              end
            end else begin
              ch_reg <= ch_reg + CW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rhd_sample_packetizer.sv
// Testbench for rhd_sample_packetizer. The bench builds the expected output
// stream per packet from the framing rules (header words, optional counter,
// channel data, tlast on the final word) and one negedge process compares
// every accepted output word against it, plus hold/stall checks.
module tb_rhd_sample_packetizer;

  localparam int NUM_CH = 32;
`ifdef RHD_PKT_TIMESTAMP_EN
  localparam int HW        = 3;
  localparam int BASIC_LEN = 280;  // 8 * 35
  localparam int LEN3      = 105;  // 3 * 35
  localparam int DIS_LAST  = 139;  // 4 * 35 - 1
`else
  localparam int HW        = 2;
  localparam int BASIC_LEN = 272;  // 8 * 34
  localparam int LEN3      = 102;  // 3 * 34
  localparam int DIS_LAST  = 135;  // 4 * 34 - 1
`endif

  logic        clk;
  logic        rhd_aresetn;
  logic        enable;
  logic [7:0]  batch_size;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        err_clr;
  logic        err_len;
  logic [31:0] frame_cnt;

  rhd_sample_packetizer #(.NUM_CH(NUM_CH)) dut (
    .rhd_aclk      (clk),
    .rhd_aresetn   (rhd_aresetn),
    .enable        (enable),
    .batch_size    (batch_size),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .err_clr       (err_clr),
    .err_len       (err_len),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] rec_d[0:1023];
  int          out_words;
  int          tlast_cnt;
  int          last_tlast_idx;
  int          model_fc;
  int          seq;
  bit          bp_mode;
  bit          cmp_en;
  bit          prev_stall;
  logic [31:0] prev_d;
  logic        prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pat(input int fr, input int c);
    return 32'h5A00_0000 ^ (32'(fr) << 8) ^ 32'(c);
  endfunction

  // DMA-side ready: constant high, or a random 50% pattern.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Single compare process.
  always @(negedge clk) begin
    if (!rhd_aresetn || !cmp_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", m_axis_tdata, prev_d);
        chk("hold_last", 32'(m_axis_tlast), 32'(prev_l));
      end
      if (m_axis_tvalid && !m_axis_tready)
        chk("stall_s_tready", 32'(s_tready), 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected no output", m_axis_tdata);
        end else begin
          logic [31:0] ed;
          logic        el;
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          chk("out_data", m_axis_tdata, ed);
          chk("out_last", 32'(m_axis_tlast), 32'(el));
        end
        if (out_words < 1024) rec_d[out_words] = m_axis_tdata;
        if (m_axis_tlast) begin
          tlast_cnt++;
          last_tlast_idx = out_words;
        end
        out_words++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      prev_l     = m_axis_tlast;
    end
  end

  task automatic clear_log();
    out_words      = 0;
    tlast_cnt      = 0;
    last_tlast_idx = -1;
  endtask

  // One packet: push its expected words, then feed its input frames.
  // drop_at: input word index after which enable is released (-1 = never).
  // bad_f/bad_c: frame/channel with a wrong s_tlast; clr_bad pulses err_clr with it.
  task automatic run_packet(input int bs_in, input int drop_at, input int bad_f,
                            input int bad_c, input bit clr_bad, input bit chk_start);
    int nfr;
    nfr = (bs_in == 0) ? 1 : bs_in;
    for (int f = 0; f < nfr; f++) begin
      exp_d.push_back(32'h281349AB); exp_l.push_back(1'b0);
      exp_d.push_back(32'hC6911999); exp_l.push_back(1'b0);
`ifdef RHD_PKT_TIMESTAMP_EN
      exp_d.push_back(32'(model_fc)); exp_l.push_back(1'b0);
`endif
      for (int c = 0; c < NUM_CH; c++) begin
        exp_d.push_back(pat(seq + f, c));
        exp_l.push_back((f == nfr - 1) && (c == NUM_CH - 1));
      end
      model_fc++;
    end
    batch_size = 8'(bs_in);
    enable     = 1'b1;
    for (int f = 0; f < nfr; f++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int  idx;
        int  w;
        bit  ok;
        bit  is_bad;
        idx      = f * NUM_CH + c;
        is_bad   = (f == bad_f) && (c == bad_c);
        s_tdata  = pat(seq + f, c);
        s_tlast  = (c == NUM_CH - 1) || is_bad;
        err_clr  = clr_bad && is_bad;
        s_tvalid = 1'b1;
        if (chk_start && idx == 0) begin
          @(posedge clk);
          #1;
          chk("start_tvalid", 32'(m_axis_tvalid), 32'd1);
          chk("start_word", m_axis_tdata, 32'h281349AB);
        end
        w  = 0;
        ok = 1'b0;
        while (w < 400) begin
          @(negedge clk);
          if (s_tready) begin
            ok = 1'b1;
            break;
          end
          w++;
        end
        if (!ok) begin
          chk("accept_timeout", 32'd0, 32'd1);
        end else begin
          @(posedge clk);
          #1;
          chk("data_latency", m_axis_tdata, pat(seq + f, c));
          if (is_bad) chk("err_set", 32'(err_len), 32'd1);
        end
        err_clr = 1'b0;
        if (idx == drop_at) enable = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    seq     += nfr;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_d.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_d.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rhd_aresetn = 1'b0;
    enable      = 1'b0;
    batch_size  = 8'd0;
    s_tdata     = 32'd0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    err_clr     = 1'b0;
    bp_mode     = 1'b0;
    cmp_en      = 1'b1;
    model_fc    = 0;
    seq         = 0;
    clear_log();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    rhd_aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic packet: 8 frames, enable released during the last frame
    clear_log();
    run_packet(8, 7 * NUM_CH, -1, -1, 1'b0, 1'b1);
    drain();
    chk("basic_words", 32'(out_words), 32'(BASIC_LEN));
    chk("basic_w0", rec_d[0], 32'h281349AB);
    chk("basic_w1", rec_d[1], 32'hC6911999);
`ifdef RHD_PKT_TIMESTAMP_EN
    chk("basic_ts0", rec_d[2], 32'd0);
`endif
    chk("basic_tlast_cnt", 32'(tlast_cnt), 32'd1);
    chk("basic_tlast_idx", 32'(last_tlast_idx), 32'(BASIC_LEN - 1));
    chk("basic_frame_cnt", frame_cnt, 32'd8);
    chk("basic_err_len", 32'(err_len), 32'd0);

    // Backpressure: random tready, same expected sequence rules
    bp_mode = 1'b1;
    clear_log();
    run_packet(3, 2 * NUM_CH, -1, -1, 1'b0, 1'b0);
    drain();
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_words", 32'(out_words), 32'(LEN3));
    chk("bp_frame_cnt", frame_cnt, 32'd11);

    // batch_size = 0 -> one frame per packet, back-to-back packets
    clear_log();
    run_packet(0, -1, -1, -1, 1'b0, 1'b0);
    run_packet(0, -1, -1, -1, 1'b0, 1'b0);
    run_packet(0, 0, -1, -1, 1'b0, 1'b0);
    drain();
    chk("bs0_words", 32'(out_words), 32'(LEN3));
    chk("bs0_tlast_cnt", 32'(tlast_cnt), 32'd3);
`ifdef RHD_PKT_TIMESTAMP_EN
    chk("ts_pkt0", rec_d[2], 32'd11);
    chk("ts_pkt1", rec_d[37], 32'd12);
    chk("ts_pkt2", rec_d[72], 32'd13);
`endif
    chk("bs0_frame_cnt", frame_cnt, 32'd14);

    // Length error on channel 30 of frame 2
    chk("err_pre", 32'(err_len), 32'd0);
    run_packet(3, 2 * NUM_CH, 2, 30, 1'b0, 1'b0);
    drain();
    chk("err_sticky", 32'(err_len), 32'd1);
    chk("err_frame_cnt", frame_cnt, 32'd17);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("err_cleared", 32'(err_len), 32'd0);
    // err_clr coincident with a new mismatch: set must win (checked in run_packet)
    run_packet(1, 0, 0, 5, 1'b1, 1'b0);
    drain();
    chk("err_after_both", 32'(err_len), 32'd1);

    // Graceful disable at output word 100 of a 4-frame packet
    clear_log();
    run_packet(4, 2 * NUM_CH + 30, -1, -1, 1'b0, 1'b0);
    drain();
    repeat (40) @(negedge clk);
    chk("dis_tlast_idx", 32'(last_tlast_idx), 32'(DIS_LAST));
    chk("dis_words", 32'(out_words), 32'(DIS_LAST + 1));
    chk("dis_frame_cnt", frame_cnt, 32'd22);

    // Reset mid-packet
    cmp_en     = 1'b0;
    batch_size = 8'd2;
    enable     = 1'b1;
    s_tdata    = 32'h1234_5678;
    s_tlast    = 1'b0;
    s_tvalid   = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(m_axis_tvalid), 32'd1);
    #2;
    rhd_aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("mid_rst_tdata", m_axis_tdata, 32'd0);
    chk("mid_rst_s_tready", 32'(s_tready), 32'd0);
    chk("mid_rst_err_len", 32'(err_len), 32'd0);
    chk("mid_rst_frame_cnt", frame_cnt, 32'd0);
    s_tvalid = 1'b0;
    exp_d.delete();
    exp_l.delete();
    model_fc = 0;
    repeat (2) @(posedge clk);
    #1;
    rhd_aresetn = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    clear_log();
    run_packet(1, 0, -1, -1, 1'b0, 1'b1);
    drain();
    chk("post_rst_w0", rec_d[0], 32'h281349AB);
`ifdef RHD_PKT_TIMESTAMP_EN
    chk("post_rst_ts", rec_d[2], 32'd0);
`endif
    chk("post_rst_frame_cnt", frame_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
